// File: rtl/msx_slot_expander.sv
// msx_slot_expander
//   Primary/secondary slot decode for an MSX2-style bus.
//   - Primary slot per 16KB page comes from the PPI port A value.
//   - Primary slots flagged in EXPANDED carry a secondary slot register at
//     FFFFh. Reading it returns the inverted value.
//   - Memory-mapper segment registers sit at I/O FCh..FFh. Each register is
//     SEG_W bits wide; unused read-back bits return as ones.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   addr, d_from_cpu    CPU address and write data
//   mreq_n .. rfrsh_n   T80 bus strobes
//   ppi_slot_sel        primary slot register, 2 bits per page
//   SLTSL_n             primary slot selects
//   SSLTSL_n            secondary slot selects, index slot*4+sub
//   CS1_n, CS2_n,
//   CS12_n, CS01_n      page chip selects (reads only)
//   mapper_cs_n         mapped RAM select
//   mapper_addr         mapped RAM address {segment, offset}
//   d_out, d_out_en     register read-back data and its valid flag
module msx_slot_expander #(
  parameter logic [3:0]  EXPANDED    = 4'b1000,
  parameter int unsigned SEG_W       = 8,
  parameter int unsigned MAPPER_SLOT = 3,
  parameter int unsigned MAPPER_SUB  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       addr,
  input  logic [7:0]        d_from_cpu,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              rfrsh_n,
  input  logic [7:0]        ppi_slot_sel,
  output logic [3:0]        SLTSL_n,
  output logic [15:0]       SSLTSL_n,
  output logic              CS1_n,
  output logic              CS2_n,
  output logic              CS12_n,
  output logic              CS01_n,
  output logic              mapper_cs_n,
  output logic [SEG_W+13:0] mapper_addr,
  output logic [7:0]        d_out,
  output logic              d_out_en
);

  localparam logic [SEG_W-1:0] SEG_RST0 = SEG_W'(3);
  localparam logic [SEG_W-1:0] SEG_RST1 = SEG_W'(2);
  localparam logic [SEG_W-1:0] SEG_RST2 = SEG_W'(1);
  localparam logic [SEG_W-1:0] SEG_RST3 = SEG_W'(0);
  localparam int unsigned      MAP_IDX  = MAPPER_SLOT * 4 + MAPPER_SUB;

  logic [1:0]       w_page;
  logic [1:0]       w_p;
  logic [1:0]       w_p3;
  logic             w_memacc;
  logic             w_ffff_hit;
  logic             w_io_hit;
  logic             w_wr_pulse;
  logic             w_rd;
  logic [7:0]       w_seg_rd;
  logic [7:0]       w_ssr [4];

  logic             r_wr_q;
  logic [SEG_W-1:0] r_seg [4];

  assign w_page   = addr[15:14];
  assign w_p      = ppi_slot_sel[{w_page, 1'b0} +: 2];
  assign w_p3     = ppi_slot_sel[7:6];
  assign w_memacc = ~mreq_n & rfrsh_n;
  assign w_rd     = w_memacc & ~rd_n;

  // The subslot register lives in page 3, so it is decoded with the page-3
  // primary slot rather than the current page's slot.
  assign w_ffff_hit = w_memacc & (addr == 16'hFFFF) & EXPANDED[w_p3];

  // m1_n low with iorq_n low is an interrupt acknowledge, never a port access.
  assign w_io_hit = ~iorq_n & m1_n & (addr[7:2] == 6'b111111);

  // wr_q resets low so a write that is already active when reset releases
  // only commits after wr_n has been seen high at least once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_q <= 1'b0;
    end else begin
      r_wr_q <= wr_n;
    end
  end

  assign w_wr_pulse = ~wr_n & r_wr_q;

  for (genvar k = 0; k < 4; k++) begin : g_ssr
    if (EXPANDED[k]) begin : g_exp
      logic [7:0] r_ssr;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_ssr <= 8'h00;
        end else if (w_wr_pulse && w_ffff_hit && (w_p3 == 2'(k))) begin
          r_ssr <= d_from_cpu;
        end
      end
      assign w_ssr[k] = r_ssr;
    end else begin : g_flat
      assign w_ssr[k] = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg[0] <= SEG_RST0;
      r_seg[1] <= SEG_RST1;
      r_seg[2] <= SEG_RST2;
      r_seg[3] <= SEG_RST3;
    end else if (w_wr_pulse && w_io_hit) begin
      r_seg[addr[1:0]] <= d_from_cpu[SEG_W-1:0];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_sltsl
    assign SLTSL_n[k] = ~(w_memacc & (w_p == 2'(k)) & ~w_ffff_hit);

    for (genvar s = 0; s < 4; s++) begin : g_sub
      if (EXPANDED[k]) begin : g_exp
        // Only the subslot chosen for this page follows the primary select.
        assign SSLTSL_n[k*4+s] = (w_ssr[k][{w_page, 1'b0} +: 2] == 2'(s)) ?
                                 SLTSL_n[k] : 1'b1;
      end else begin : g_flat
        assign SSLTSL_n[k*4+s] = 1'b1;
      end
    end
  end

  assign CS1_n  = ~(w_rd & (w_page == 2'd1));
  assign CS2_n  = ~(w_rd & (w_page == 2'd2));
  assign CS12_n = ~(w_rd & ((w_page == 2'd1) | (w_page == 2'd2)));
  assign CS01_n = ~(w_rd & ((w_page == 2'd0) | (w_page == 2'd1)));

  if (EXPANDED[MAPPER_SLOT]) begin : g_map_exp
    assign mapper_cs_n = SSLTSL_n[MAP_IDX];
  end else begin : g_map_flat
    assign mapper_cs_n = SLTSL_n[MAPPER_SLOT];
  end

  assign mapper_addr = {r_seg[w_page], addr[13:0]};

  always_comb begin
    w_seg_rd              = 8'hFF;
    w_seg_rd[SEG_W-1:0]   = r_seg[addr[1:0]];
    d_out                 = 8'hFF;
    d_out_en              = 1'b0;
    if (w_ffff_hit && !rd_n) begin
      d_out    = ~w_ssr[w_p3];
      d_out_en = 1'b1;
    end else if (w_io_hit && !rd_n) begin
      d_out    = w_seg_rd;
      d_out_en = 1'b1;
    end
  end

endmodule

// File: tb/tb_msx_slot_expander.sv
module tb_msx_slot_expander;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n;
  logic [7:0]  ppi_slot_sel;

  always #5 clk = ~clk;

  // instance 0: default parameters; instance 1: nothing expanded, 5-bit segments
  logic [3:0]  s0_sltsl, s1_sltsl;
  logic [15:0] s0_ssltsl, s1_ssltsl;
  logic        s0_cs1, s0_cs2, s0_cs12, s0_cs01, s1_cs1, s1_cs2, s1_cs12, s1_cs01;
  logic        s0_mcs, s1_mcs;
  logic [21:0] s0_maddr;
  logic [18:0] s1_maddr;
  logic [7:0]  s0_dout, s1_dout;
  logic        s0_den, s1_den;

  msx_slot_expander dut0 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .d_from_cpu(d_from_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .rfrsh_n(rfrsh_n), .ppi_slot_sel(ppi_slot_sel),
    .SLTSL_n(s0_sltsl), .SSLTSL_n(s0_ssltsl),
    .CS1_n(s0_cs1), .CS2_n(s0_cs2), .CS12_n(s0_cs12), .CS01_n(s0_cs01),
    .mapper_cs_n(s0_mcs), .mapper_addr(s0_maddr), .d_out(s0_dout), .d_out_en(s0_den)
  );

  msx_slot_expander #(.EXPANDED(4'b0000), .SEG_W(5), .MAPPER_SLOT(1), .MAPPER_SUB(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .d_from_cpu(d_from_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .rfrsh_n(rfrsh_n), .ppi_slot_sel(ppi_slot_sel),
    .SLTSL_n(s1_sltsl), .SSLTSL_n(s1_ssltsl),
    .CS1_n(s1_cs1), .CS2_n(s1_cs2), .CS12_n(s1_cs12), .CS01_n(s1_cs01),
    .mapper_cs_n(s1_mcs), .mapper_addr(s1_maddr), .d_out(s1_dout), .d_out_en(s1_den)
  );

  logic [3:0]  sltsl [2];
  logic [15:0] ssltsl [2];
  logic [3:0]  cs [2];
  logic        mcs [2];
  logic [21:0] maddr [2];
  logic [7:0]  dout [2];
  logic        den [2];

  always_comb begin
    sltsl[0]  = s0_sltsl;  sltsl[1]  = s1_sltsl;
    ssltsl[0] = s0_ssltsl; ssltsl[1] = s1_ssltsl;
    cs[0]     = {s0_cs1, s0_cs2, s0_cs12, s0_cs01};
    cs[1]     = {s1_cs1, s1_cs2, s1_cs12, s1_cs01};
    mcs[0]    = s0_mcs;    mcs[1]    = s1_mcs;
    maddr[0]  = s0_maddr;  maddr[1]  = {3'b000, s1_maddr};
    dout[0]   = s0_dout;   dout[1]   = s1_dout;
    den[0]    = s0_den;    den[1]    = s1_den;
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_ssr [2][4];
  logic [7:0] m_seg [2][4];

  function automatic logic [3:0] cfg_exp(int i); return (i == 0) ? 4'b1000 : 4'b0000; endfunction
  function automatic int cfg_sw(int i);   return (i == 0) ? 8 : 5; endfunction
  function automatic int cfg_ms(int i);   return (i == 0) ? 3 : 1; endfunction
  function automatic int cfg_msub(int i); return (i == 0) ? 0 : 0; endfunction
  function automatic logic [7:0] mask(int i); return 8'((1 << cfg_sw(i)) - 1); endfunction

  function automatic int cur_page(); return int'(addr[15:14]); endfunction
  function automatic int slot_of(int pg); return int'((ppi_slot_sel >> (2 * pg)) & 8'h03); endfunction
  function automatic bit is_memacc(); return !mreq_n && rfrsh_n; endfunction
  function automatic bit is_io(); return !iorq_n && m1_n && (addr[7:0] >= 8'hFC); endfunction

  function automatic bit is_ffff(int i);
    logic [3:0] e;
    e = cfg_exp(i);
    return is_memacc() && (addr == 16'hFFFF) && e[slot_of(3)];
  endfunction

  function automatic logic [3:0] exp_sltsl(int i);
    logic [3:0] r;
    r = 4'hF;
    if (is_memacc() && !is_ffff(i)) r[slot_of(cur_page())] = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] exp_ssltsl(int i);
    logic [15:0] r;
    logic [3:0]  s, e;
    int p, sub;
    r = 16'hFFFF;
    s = exp_sltsl(i);
    e = cfg_exp(i);
    p = slot_of(cur_page());
    if (e[p] && !s[p]) begin
      sub = int'((m_ssr[i][p] >> (2 * cur_page())) & 8'h03);
      r[p*4+sub] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic exp_mcs(int i);
    logic [3:0]  s, e;
    logic [15:0] ss;
    s  = exp_sltsl(i);
    ss = exp_ssltsl(i);
    e  = cfg_exp(i);
    if (e[cfg_ms(i)]) return ss[cfg_ms(i)*4 + cfg_msub(i)];
    return s[cfg_ms(i)];
  endfunction

  function automatic logic [3:0] exp_cs();
    bit rd;
    int pg;
    rd = is_memacc() && !rd_n;
    pg = cur_page();
    return {!(rd && pg == 1), !(rd && pg == 2), !(rd && (pg == 1 || pg == 2)), !(rd && pg < 2)};
  endfunction

  function automatic logic [21:0] exp_maddr(int i);
    return (22'(m_seg[i][cur_page()]) << 14) | 22'(addr[13:0]);
  endfunction

  function automatic logic [7:0] exp_dout(int i);
    if (is_ffff(i) && !rd_n) return ~m_ssr[i][slot_of(3)];
    if (is_io() && !rd_n)    return m_seg[i][addr[1:0]] | ~mask(i);
    return 8'hFF;
  endfunction

  function automatic logic exp_den(int i);
    return (is_ffff(i) && !rd_n) || (is_io() && !rd_n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_ssr[i][k] = 8'h00;
        m_seg[i][k] = 8'(3 - k) & mask(i);
      end
    end
  endtask

  // one bus write commits once, using the bus as it stands
  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      if (is_ffff(i)) m_ssr[i][slot_of(3)] = d_from_cpu;
      if (is_io())    m_seg[i][addr[1:0]]  = d_from_cpu & mask(i);
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic bus_set(input logic mq, input logic iq, input logic rd, input logic wr,
                         input logic m1, input logic rf, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    mreq_n = mq; iorq_n = iq; rd_n = rd; wr_n = wr; m1_n = m1; rfrsh_n = rf;
    addr = a; d_from_cpu = d;
  endtask

  task automatic bus_idle();
    bus_set(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
  endtask

  // drive a write, let it commit on the next edge, then release the strobes
  task automatic do_write(input logic mq, input logic iq, input logic m1, input logic rf,
                          input logic [15:0] a, input logic [7:0] d);
    bus_set(mq, iq, 1'b1, 1'b0, m1, rf, a, d);
    @(posedge clk);
    model_commit();
    #1;
    wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfrsh_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfrsh_n = 1'b1;
    addr = 16'h0000; d_from_cpu = 8'h00; ppi_slot_sel = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (sltsl[i] !== 4'hF) begin n_errors++; $display("FAIL reset_sltsl inst%0d got %b exp 1111", i, sltsl[i]); end
      n_checks++; if (ssltsl[i] !== 16'hFFFF) begin n_errors++; $display("FAIL reset_ssltsl inst%0d got %h exp ffff", i, ssltsl[i]); end
      n_checks++; if (cs[i] !== 4'hF) begin n_errors++; $display("FAIL reset_cs inst%0d got %b exp 1111", i, cs[i]); end
      n_checks++; if (mcs[i] !== 1'b1) begin n_errors++; $display("FAIL reset_mcs inst%0d got %b exp 1", i, mcs[i]); end
      n_checks++; if (den[i] !== 1'b0 || dout[i] !== 8'hFF) begin n_errors++; $display("FAIL reset_dout inst%0d got %b/%h exp 0/ff", i, den[i], dout[i]); end
      n_checks++; if (maddr[i] !== 22'h00C000) begin n_errors++; $display("FAIL reset_maddr inst%0d got %h exp 0c000", i, maddr[i]); end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_primary_read();
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    @(negedge clk);
    n_checks++; if (sltsl[0] !== 4'b0111) begin n_errors++; $display("FAIL plan_sltsl got %b exp 0111", sltsl[0]); end
    n_checks++; if (ssltsl[0] !== 16'hEFFF) begin n_errors++; $display("FAIL plan_ssltsl got %h exp efff", ssltsl[0]); end
    n_checks++; if (mcs[0] !== 1'b0) begin n_errors++; $display("FAIL plan_mcs got %b exp 0", mcs[0]); end
    n_checks++; if (maddr[0] !== 22'h00C000) begin n_errors++; $display("FAIL plan_maddr got %h exp 0c000", maddr[0]); end
    n_checks++; if (cs[0] !== 4'b1110) begin n_errors++; $display("FAIL plan_cs got %b exp 1110", cs[0]); end
    n_checks++; if (ssltsl[1] !== 16'hFFFF || mcs[1] !== 1'b1) begin n_errors++; $display("FAIL plan_flat got %h/%b exp ffff/1", ssltsl[1], mcs[1]); end
  endtask

  task automatic test_ssr_write();
    bus_set(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'hE4);
    @(negedge clk);
    n_checks++; if (sltsl[0] !== 4'hF || ssltsl[0] !== 16'hFFFF) begin n_errors++; $display("FAIL ffff_wr_hold got %b/%h exp 1111/ffff", sltsl[0], ssltsl[0]); end
    n_checks++; if (sltsl[1] !== 4'b0111) begin n_errors++; $display("FAIL ffff_wr_flat got %b exp 0111", sltsl[1]); end
    @(posedge clk);
    model_commit();
    #1 wr_n = 1'b1; mreq_n = 1'b1;
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h00);
    @(negedge clk);
    n_checks++; if (dout[0] !== 8'h1B || den[0] !== 1'b1) begin n_errors++; $display("FAIL ffff_rd got %h/%b exp 1b/1", dout[0], den[0]); end
    n_checks++; if (sltsl[0][3] !== 1'b1) begin n_errors++; $display("FAIL ffff_rd_sltsl got %b exp 1", sltsl[0][3]); end
    n_checks++; if (den[1] !== 1'b0 || dout[1] !== 8'hFF) begin n_errors++; $display("FAIL ffff_rd_flat got %b/%h exp 0/ff", den[1], dout[1]); end
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 8'h00);
    @(negedge clk);
    n_checks++; if (ssltsl[0] !== 16'hBFFF) begin n_errors++; $display("FAIL sub_p2 got %h exp bfff", ssltsl[0]); end
    n_checks++; if (mcs[0] !== 1'b1) begin n_errors++; $display("FAIL sub_p2_mcs got %b exp 1", mcs[0]); end
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hC123, 8'h00);
    @(negedge clk);
    n_checks++; if (ssltsl[0] !== 16'h7FFF) begin n_errors++; $display("FAIL sub_p3 got %h exp 7fff", ssltsl[0]); end
  endtask

  task automatic test_mapper_io();
    do_write(1'b1, 1'b0, 1'b1, 1'b1, 16'h12FE, 8'h25);
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 8'h00);
    @(negedge clk);
    n_checks++; if (maddr[0] !== 22'h094000) begin n_errors++; $display("FAIL map_addr8 got %h exp 94000", maddr[0]); end
    n_checks++; if (maddr[1] !== 22'h014000) begin n_errors++; $display("FAIL map_addr5 got %h exp 14000", maddr[1]); end
    bus_set(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h34FE, 8'h00);
    @(negedge clk);
    n_checks++; if (dout[0] !== 8'h25 || den[0] !== 1'b1) begin n_errors++; $display("FAIL io_rd8 got %h/%b exp 25/1", dout[0], den[0]); end
    n_checks++; if (dout[1] !== 8'hE5 || den[1] !== 1'b1) begin n_errors++; $display("FAIL io_rd5 got %h/%b exp e5/1", dout[1], den[1]); end
    bus_set(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00FE, 8'h00);
    @(negedge clk);
    n_checks++; if (den[0] !== 1'b0) begin n_errors++; $display("FAIL inta_hit got %b exp 0", den[0]); end
    bus_set(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00FB, 8'h00);
    @(negedge clk);
    n_checks++; if (den[0] !== 1'b0) begin n_errors++; $display("FAIL io_miss got %b exp 0", den[0]); end
  endtask

  task automatic test_long_write();
    bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00FC, 8'h07);
    @(posedge clk);
    #1 d_from_cpu = 8'h11;
    repeat (9) @(posedge clk);
    #1 wr_n = 1'b1; iorq_n = 1'b1;
    for (int i = 0; i < 2; i++) m_seg[i][0] = 8'h07 & mask(i);
    bus_set(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00FC, 8'h00);
    @(negedge clk);
    n_checks++; if (dout[0] !== 8'h07) begin n_errors++; $display("FAIL long_wr8 got %h exp 07", dout[0]); end
    n_checks++; if (dout[1] !== 8'hE7) begin n_errors++; $display("FAIL long_wr5 got %h exp e7", dout[1]); end
  endtask

  task automatic test_reset_mid_write();
    bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00FC, 8'h09);
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (maddr[0] !== 22'h00C0FC || maddr[1] !== 22'h00C0FC) begin n_errors++; $display("FAIL async_rst got %h/%h exp 0c0fc", maddr[0], maddr[1]); end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 wr_n = 1'b1; iorq_n = 1'b1;
    bus_set(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00FC, 8'h00);
    @(negedge clk);
    n_checks++; if (dout[0] !== 8'h03) begin n_errors++; $display("FAIL rst_nocommit8 got %h exp 03", dout[0]); end
    n_checks++; if (dout[1] !== 8'hE3) begin n_errors++; $display("FAIL rst_nocommit5 got %h exp e3", dout[1]); end
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h00);
    @(negedge clk);
    n_checks++; if (dout[0] !== 8'hFF || den[0] !== 1'b1) begin n_errors++; $display("FAIL rst_ssr got %h/%b exp ff/1", dout[0], den[0]); end
  endtask

  task automatic test_refresh();
    logic [15:0] a;
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 16'hFFFF : (t == 1) ? 16'h0000 : 16'($urandom);
      bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (sltsl[i] !== 4'hF || ssltsl[i] !== 16'hFFFF || mcs[i] !== 1'b1 || cs[i] !== 4'hF || den[i] !== 1'b0) begin
          n_errors++;
          $display("FAIL refresh inst%0d a=%h got %b/%h/%b/%b/%b exp all high, den 0", i, a, sltsl[i], ssltsl[i], mcs[i], cs[i], den[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int op;
    logic [15:0] a;
    logic [7:0]  d;
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 6));
      d  = 8'($urandom);
      a  = 16'($urandom);
      if (op <= 1 && $urandom_range(0, 2) == 0) a = 16'hFFFF;
      if ((op == 2 || op == 3 || op == 4) && $urandom_range(0, 3) != 0) a[7:2] = 6'b111111;
      if ($urandom_range(0, 3) == 0) begin
        #0;
      end
      case (op)
        0: bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, a, d);
        1: bus_set(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, a, d);
        2: bus_set(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a, d);
        3: bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, a, d);
        4: bus_set(1'b1, 1'b0, 1'b0, 1'($urandom), 1'b0, 1'b1, a, d);
        5: bus_set(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0, a, d);
        default: bus_set(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, a, d);
      endcase
      ppi_slot_sel = 8'($urandom);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (sltsl[i] !== exp_sltsl(i)) begin n_errors++; $display("FAIL rnd_sltsl inst%0d it%0d got %b exp %b", i, it, sltsl[i], exp_sltsl(i)); end
        n_checks++; if (ssltsl[i] !== exp_ssltsl(i)) begin n_errors++; $display("FAIL rnd_ssltsl inst%0d it%0d got %h exp %h", i, it, ssltsl[i], exp_ssltsl(i)); end
        n_checks++; if (cs[i] !== exp_cs()) begin n_errors++; $display("FAIL rnd_cs inst%0d it%0d got %b exp %b", i, it, cs[i], exp_cs()); end
        n_checks++; if (mcs[i] !== exp_mcs(i)) begin n_errors++; $display("FAIL rnd_mcs inst%0d it%0d got %b exp %b", i, it, mcs[i], exp_mcs(i)); end
        n_checks++; if (maddr[i] !== exp_maddr(i)) begin n_errors++; $display("FAIL rnd_maddr inst%0d it%0d got %h exp %h", i, it, maddr[i], exp_maddr(i)); end
        n_checks++; if (dout[i] !== exp_dout(i) || den[i] !== exp_den(i)) begin n_errors++; $display("FAIL rnd_dout inst%0d it%0d got %h/%b exp %h/%b", i, it, dout[i], den[i], exp_dout(i), exp_den(i)); end
      end
      if (wr_n == 1'b0) begin
        @(posedge clk);
        model_commit();
        #1;
        wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfrsh_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_primary_read();
    test_ssr_write();
    test_mapper_io();
    test_long_write();
    test_reset_mid_write();
    test_refresh();
    bus_idle();
    test_random();
    bus_idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
